// File: rtl/hour_counter_cfg.sv
// Purpose: binary 0-23 hour register with run-time 12/24-hour BCD display mapping and a day-carry pulse.
// Latency: state updates on the sampling edge; digits and pm follow combinationally from the stored hour.
// Backpressure: none; tick, adjust and load strobes are accepted on every cycle.
module hour_counter_cfg #(
  parameter int UNIT_W     = 4,
  parameter int TEN_W      = 2,
  parameter int RESET_HOUR = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_h,
  input  logic              up,
  input  logic              down,
  input  logic              mode_12,
  input  logic              load,
  input  logic [4:0]        load_hour,
  output logic [UNIT_W-1:0] hour_unit,
  output logic [TEN_W-1:0]  hour_ten,
  output logic              pm,
  output logic              pulse_day
);

  // An out-of-range reset hour would leave the register outside its legal cycle.
  if (RESET_HOUR < 0 || RESET_HOUR > 23) begin : g_bad_reset_hour
    $error("hour_counter_cfg: RESET_HOUR must be in 0..23");
  end

  localparam logic [4:0] RST_HR = 5'(RESET_HOUR);

  logic [4:0] hr;
  logic [4:0] disp;
  logic [4:0] ten_v;
  logic [4:0] unit_v;

  // Hour register: load beats adjust beats tick; only a tick wrapping 23->0 raises the day carry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hr        <= RST_HR;
      pulse_day <= 1'b0;
    end else begin
      pulse_day <= 1'b0;
      if (load) begin
        // An illegal load value is dropped, and it still blocks adjust/tick this cycle.
        if (load_hour <= 5'd23) begin
          hr <= load_hour;
        end
      end else if (up ^ down) begin
        if (up) begin
          hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        end else begin
          hr <= (hr == 5'd0) ? 5'd23 : hr - 5'd1;
        end
      end else if (en_h) begin
        // up and down together cancel, so a tick in that cycle still advances the hour.
        hr <= (hr == 5'd23) ? 5'd0 : hr + 5'd1;
        pulse_day <= (hr == 5'd23);
      end
    end
  end

  // Display mapping: pick the shown value, then split it into ten and unit digits.
  always_comb begin
    disp = hr;
    if (mode_12) begin
      if (hr == 5'd0) begin
        disp = 5'd12;
      end else if (hr > 5'd12) begin
        disp = hr - 5'd12;
      end
    end
    if (disp >= 5'd20) begin
      ten_v  = 5'd2;
      unit_v = disp - 5'd20;
    end else if (disp >= 5'd10) begin
      ten_v  = 5'd1;
      unit_v = disp - 5'd10;
    end else begin
      ten_v  = 5'd0;
      unit_v = disp;
    end
  end

  assign hour_ten  = TEN_W'(ten_v);
  assign hour_unit = UNIT_W'(unit_v);
  assign pm        = (hr >= 5'd12);

endmodule

// File: tb/tb_hour_counter_cfg.sv
// Purpose: self-checking bench for hour_counter_cfg using a vector table, a tick loop and hand-written corner cases.
// Latency: each vector is driven on a falling edge and its result is checked 1 time unit after the next rising edge.
// Backpressure: not applicable; the bench drives one vector per clock cycle.
module tb_hour_counter_cfg;

  logic       clk;
  logic       rst;
  logic       en_h;
  logic       up;
  logic       down;
  logic       mode_12;
  logic       load;
  logic [4:0] load_hour;
  logic [3:0] hour_unit;
  logic [1:0] hour_ten;
  logic       pm;
  logic       pulse_day;

  int n_total;
  int n_pass;

  typedef struct {
    logic       ld;
    logic [4:0] lh;
    logic       u;
    logic       d;
    logic       en;
    logic       m12;
    int         ten;
    int         unit;
    int         pm;
    int         pd;
    string      name;
  } vec_t;

  typedef struct {
    int    ten;
    int    unit;
    int    pm;
    int    pd;
    string name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];

  hour_counter_cfg #(
    .UNIT_W(4),
    .TEN_W(2),
    .RESET_HOUR(0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_h(en_h),
    .up(up),
    .down(down),
    .mode_12(mode_12),
    .load(load),
    .load_hour(load_hour),
    .hour_unit(hour_unit),
    .hour_ten(hour_ten),
    .pm(pm),
    .pulse_day(pulse_day)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends even if the clocking stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not reach its summary line");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_outputs(input exp_t e);
    check({e.name, ".ten"},   int'(hour_ten),  e.ten);
    check({e.name, ".unit"},  int'(hour_unit), e.unit);
    check({e.name, ".pm"},    int'(pm),        e.pm);
    check({e.name, ".pulse"}, int'(pulse_day), e.pd);
  endtask

  // Drive one vector, queue its expectation, then pop and compare after the clock edge.
  task automatic step(input vec_t v);
    exp_t e;
    @(negedge clk);
    load      = v.ld;
    load_hour = v.lh;
    up        = v.u;
    down      = v.d;
    en_h      = v.en;
    mode_12   = v.m12;
    sb.push_back('{v.ten, v.unit, v.pm, v.pd, v.name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(e);
  endtask

  initial begin
    vec_t v;
    int   h;

    n_total   = 0;
    n_pass    = 0;
    rst       = 1'b1;
    en_h      = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    mode_12   = 1'b0;
    load      = 1'b0;
    load_hour = 5'd0;

    // Reset state in both display modes.
    #12;
    check_outputs('{0, 0, 0, 0, "reset_24h"});
    mode_12 = 1'b1;
    #1;
    check_outputs('{1, 2, 0, 0, "reset_12h"});
    @(negedge clk);
    rst     = 1'b0;
    mode_12 = 1'b0;

    // 24 consecutive ticks from 00: full day, carry only on the 23->00 tick.
    for (int i = 1; i <= 24; i++) begin
      h = i % 24;
      v = '{1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, h / 10, h % 10,
            (h >= 12) ? 1 : 0, (i == 24) ? 1 : 0, $sformatf("tick%0d", i)};
      step(v);
    end

    // Vector table: {load, load_hour, up, down, en_h, mode_12, ten, unit, pm, pulse_day, name}.
    tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, "idle_after_wrap"});
    tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 2, 3, 1, 0, "down_wrap"});
    tbl.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, "up_wrap"});
    tbl.push_back('{1'b1, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, 0, 5, 0, 0, "load5"});
    tbl.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 0, 6, 0, 0, "updown_tick"});
    tbl.push_back('{1'b0, 5'd0,  1'b1, 1'b1, 1'b0, 1'b0, 0, 6, 0, 0, "updown_hold"});
    tbl.push_back('{1'b1, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, "load13_12h"});
    tbl.push_back('{1'b1, 5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 0, 7, 0, 0, "load_beats_all"});
    tbl.push_back('{1'b1, 5'd24, 1'b1, 1'b0, 1'b0, 1'b0, 0, 7, 0, 0, "load24_ignored"});
    tbl.push_back('{1'b1, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 0, 0, "midnight_12h"});
    tbl.push_back('{1'b1, 5'd12, 1'b0, 1'b0, 1'b0, 1'b1, 1, 2, 1, 0, "noon_12h"});
    tbl.push_back('{1'b1, 5'd23, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 1, 0, "eleven_pm"});
    tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b1, 1, 2, 0, 1, "tick_wrap_12h"});
    tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, "pulse_one_cycle"});
    tbl.push_back('{1'b0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 2, 3, 1, 0, "down_drops_tick"});
    tbl.push_back('{1'b0, 5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, "up_wrap_no_pulse"});
    tbl.push_back('{1'b1, 5'd22, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 1, 0, "load_drops_tick"});
    tbl.push_back('{1'b1, 5'd31, 1'b0, 1'b0, 1'b1, 1'b0, 2, 2, 1, 0, "bad_load_no_tick"});
    foreach (tbl[i]) step(tbl[i]);

    // mode_12 is display-only: load 13 in 12h mode, then flip to 24h with no clock edge.
    step('{1'b1, 5'd13, 1'b0, 1'b0, 1'b0, 1'b1, 0, 1, 1, 0, "load13_again"});
    @(negedge clk);
    load    = 1'b0;
    mode_12 = 1'b1;
    #1;
    check_outputs('{0, 1, 1, 0, "mode12_shows_01"});
    mode_12 = 1'b0;
    #1;
    check_outputs('{1, 3, 1, 0, "mode24_same_cycle"});

    // Asynchronous reset while the day-carry pulse is high.
    step('{1'b1, 5'd23, 1'b0, 1'b0, 1'b0, 1'b0, 2, 3, 1, 0, "load23"});
    step('{1'b0, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0, 1, "wrap_before_rst"});
    @(negedge clk);
    en_h = 1'b0;
    load = 1'b1;
    load_hour = 5'd9;
    #1;
    rst = 1'b1;
    #1;
    check_outputs('{0, 0, 0, 0, "async_rst_mid_pulse"});
    @(negedge clk);
    rst  = 1'b0;
    load = 1'b0;
    step('{1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, "hold_after_rst"});

    check("scoreboard_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
